// File: rtl/result_bcd_converter_pkg.sv
// Shared types and constants for the result-to-BCD conversion path.
package result_bcd_converter_pkg;

  localparam int RESULT_WIDTH  = 16;
  localparam int RESULT_DIGITS = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ADJUST = 3'd2,
    SHIFT  = 3'd3,
    FINISH = 3'd4
  } bcd_state_t;

  // True when DIGITS decimal digits can hold every WIDTH-bit magnitude.
  function automatic bit bcd_fits(input int width, input int digits);
    longint p10;
    longint p2;
    p10 = 1;
    p2  = 1;
    for (int i = 0; i < digits; i++) p10 = p10 * 10;
    for (int i = 0; i < width; i++) p2 = p2 * 2;
    return p10 > p2;
  endfunction

endpackage

// File: rtl/result_bcd_converter_if.sv
// Start/Busy/Done handshake plus operand and BCD result bundle.
interface result_bcd_converter_if
  import result_bcd_converter_pkg::*;
#(
  parameter int WIDTH  = RESULT_WIDTH,
  parameter int DIGITS = RESULT_DIGITS
);

  logic                  start;
  logic                  signed_mode;
  logic [WIDTH-1:0]      value;
  logic                  busy;
  logic                  done;
  logic                  negative;
  logic [4*DIGITS-1:0]   bcd;

  modport master (
    output start, signed_mode, value,
    input  busy, done, negative, bcd
  );

  modport slave (
    input  start, signed_mode, value,
    output busy, done, negative, bcd
  );

endinterface

// File: rtl/result_bcd_converter_add3.sv
// Double-dabble digit correction: add 3 to any digit of 5 or more.
module result_bcd_converter_add3 (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/result_bcd_converter.sv
// Sequential double-dabble converter: one ADJUST/SHIFT pair per operand bit.
// state  | meaning
// IDLE   | waiting for start, operand captured on acceptance
// LOAD   | clear scratch and iteration count
// ADJUST | +3 correction on every scratch digit
// SHIFT  | shift {scratch, bin} left, finish after the last bit
// FINISH | one-cycle done pulse
module result_bcd_converter
  import result_bcd_converter_pkg::*;
#(
  parameter int WIDTH  = RESULT_WIDTH,
  parameter int DIGITS = RESULT_DIGITS
) (
  input  logic                   clk,
  input  logic                   rst,
  result_bcd_converter_if.slave  io
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SW = 4 * DIGITS;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (!bcd_fits(WIDTH, DIGITS)) begin : g_digits_check
    $fatal(1, "result_bcd_converter: DIGITS too small for WIDTH");
  end

  bcd_state_t      state;
  bcd_state_t      state_nxt;
  logic [CW-1:0]   count;
  logic [WIDTH-1:0] bin;
  logic [SW-1:0]   scratch;
  logic [SW-1:0]   adjusted;
  logic [SW-1:0]   bcd_q;
  logic            sign;
  logic            negative_q;
  logic [WIDTH:0]  neg_mag;
  logic [SW-1:0]   scratch_shifted;

  for (genvar d = 0; d < DIGITS; d++) begin : g_add3
    result_bcd_converter_add3 u_add3 (
      .digit    (scratch[4*d +: 4]),
      .adjusted (adjusted[4*d +: 4])
    );
  end

  // Sign-extended negation keeps the most-negative operand exact.
  assign neg_mag         = ~{io.value[WIDTH-1], io.value} + (WIDTH+1)'(1);
  assign scratch_shifted = {scratch[SW-2:0], bin[WIDTH-1]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (io.start) state_nxt = LOAD;
      LOAD:    state_nxt = ADJUST;
      ADJUST:  state_nxt = SHIFT;
      SHIFT:   state_nxt = (count == LAST) ? FINISH : ADJUST;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    io.busy = (state != IDLE);
    io.done = (state == FINISH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      bin        <= '0;
      scratch    <= '0;
      sign       <= 1'b0;
      bcd_q      <= '0;
      negative_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (io.start) begin
            if (io.signed_mode && io.value[WIDTH-1]) begin
              bin  <= neg_mag[WIDTH-1:0];
              sign <= 1'b1;
            end else begin
              bin  <= io.value;
              sign <= 1'b0;
            end
          end
        end
        LOAD: begin
          scratch <= '0;
          count   <= '0;
        end
        ADJUST: scratch <= adjusted;
        SHIFT: begin
          scratch <= scratch_shifted;
          bin     <= {bin[WIDTH-2:0], 1'b0};
          if (count == LAST) begin
            bcd_q      <= scratch_shifted;
            negative_q <= sign;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign io.bcd      = bcd_q;
  assign io.negative = negative_q;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Scoreboard bench for result_bcd_converter (WIDTH=16, DIGITS=5).
module tb_result_bcd_converter;

  typedef struct packed {
    logic [19:0] bcd;
    logic        neg;
  } exp_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  exp_t exp_q[$];
  exp_t last_exp;

  result_bcd_converter_if #(.WIDTH(16), .DIGITS(5)) io ();

  result_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic exp_t model(input logic sm, input logic [15:0] v);
    exp_t e;
    int unsigned mag;
    mag = (sm && v[15]) ? 32'd65536 - 32'(v) : 32'(v);
    e.neg = sm && v[15];
    e.bcd = '0;
    for (int d = 0; d < 5; d++) begin
      e.bcd[4*d +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && io.done === 1'b1) begin
      check_val("expected_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check_val("bcd", 32'(io.bcd), 32'(e.bcd));
        check_val("negative", 32'(io.negative), 32'(e.neg));
      end
    end
  end

  // Called at #1 after the edge that accepted start; returns edges counted inclusive.
  task automatic wait_done(input bit disturb, output int lat, output bit busy_ok);
    lat     = 1;
    busy_ok = 1'b1;
    while (io.done !== 1'b1 && lat < 100) begin
      if (io.busy !== 1'b1) busy_ok = 1'b0;
      if (disturb && lat == 10) begin
        io.start = 1'b1;
        io.value = 16'h1111;
      end
      if (disturb && lat == 11) io.start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_conv(input logic sm, input logic [15:0] v, input bit disturb, input bit hold_start);
    int lat;
    bit busy_ok;
    @(negedge clk);
    io.signed_mode = sm;
    io.value       = v;
    io.start       = 1'b1;
    last_exp       = model(sm, v);
    exp_q.push_back(last_exp);
    @(posedge clk); #1;
    if (!hold_start) io.start = 1'b0;
    wait_done(disturb, lat, busy_ok);
    check_val("latency", 32'(lat), 32'd34);
    check_val("busy_during", 32'(busy_ok && io.busy === 1'b1), 32'd1);
    @(posedge clk); #1;
    check_val("done_width", 32'(io.done), 32'd0);
    check_val("busy_after", 32'(io.busy), 32'd0);
    check_val("bcd_hold", 32'(io.bcd), 32'(last_exp.bcd));
    if (hold_start) begin
      exp_q.push_back(last_exp);
      @(posedge clk); #1;
      check_val("restart_accepted", 32'(io.busy), 32'd1);
      io.start = 1'b0;
      wait_done(1'b0, lat, busy_ok);
      check_val("restart_latency", 32'(lat), 32'd34);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst            = 1'b1;
    io.start       = 1'b1;
    io.signed_mode = 1'b0;
    io.value       = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", 32'(io.busy), 32'd0);
    check_val("rst_done", 32'(io.done), 32'd0);
    check_val("rst_negative", 32'(io.negative), 32'd0);
    check_val("rst_bcd", 32'(io.bcd), 32'd0);
    io.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    run_conv(1'b0, 16'h0000, 1'b0, 1'b0);
    run_conv(1'b0, 16'hFFFF, 1'b0, 1'b0);
    run_conv(1'b1, 16'hFF85, 1'b0, 1'b0);
    run_conv(1'b1, 16'h8000, 1'b0, 1'b0);
    run_conv(1'b0, 16'h04D2, 1'b1, 1'b0);
    repeat (40) @(posedge clk);
    run_conv(1'b1, 16'h8001, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)
      run_conv(1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)), 1'b0, 1'b0);
    run_conv(1'b1, 16'h8001, 1'b0, 1'b0);

    // Abort mid-conversion.
    @(negedge clk);
    io.signed_mode = 1'b0;
    io.value       = 16'h1234;
    io.start       = 1'b1;
    @(posedge clk); #1;
    io.start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check_val("busy_before_reset", 32'(io.busy), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check_val("abort_busy", 32'(io.busy), 32'd0);
    check_val("abort_done", 32'(io.done), 32'd0);
    check_val("abort_bcd", 32'(io.bcd), 32'd0);
    check_val("abort_negative", 32'(io.negative), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    run_conv(1'b0, 16'h002A, 1'b0, 1'b0);

    repeat (5) @(posedge clk);
    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
